// File: rtl/if_fetch_stage_if.sv
// Fetch-stage bus: hazard controls, redirect, instruction memory data and
// the registered IF/ID outputs, bundled for if_fetch_stage.
// Optional feature macro: IF_STALL_COUNTER_EN adds the stall_count signal.
interface if_fetch_stage_if;
  logic        pc_write;
  logic        if_id_write;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_plus4;
  logic        if_id_valid;
`ifdef IF_STALL_COUNTER_EN
  logic [15:0] stall_count;

  modport master (
    input  pc_write, if_id_write, branch_taken, branch_target, imem_rdata,
    output pc, if_id_instruction, if_id_pc_plus4, if_id_valid, stall_count
  );
  modport slave (
    output pc_write, if_id_write, branch_taken, branch_target, imem_rdata,
    input  pc, if_id_instruction, if_id_pc_plus4, if_id_valid, stall_count
  );
`else
  modport master (
    input  pc_write, if_id_write, branch_taken, branch_target, imem_rdata,
    output pc, if_id_instruction, if_id_pc_plus4, if_id_valid
  );
  modport slave (
    output pc_write, if_id_write, branch_taken, branch_target, imem_rdata,
    input  pc, if_id_instruction, if_id_pc_plus4, if_id_valid
  );
`endif
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register plus the IF/ID pipeline register.
// Priority per edge: reset > branch redirect > stall > normal advance.
// pc_write and if_id_write act independently; a redirect flushes IF/ID to a
// bubble carrying NOP_WORD. All outputs come straight from registers.
// Optional feature macro: IF_STALL_COUNTER_EN adds a saturating 16-bit count
// of edges where the PC was held by hazard detection (no redirect).
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  if_fetch_stage_if.master  bus
);

  logic [31:0] pc_q,    pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q,   pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4_s;

  // Sequential next-pc (wraps modulo 2^32 naturally).
  assign pc_plus4_s = pc_q + 32'd4;

  // Next-state selection for PC and IF/ID: redirect beats stall beats advance.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bus.branch_taken) begin
      pc_d    = bus.branch_target;
      instr_d = NOP_WORD;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else begin
      if (bus.pc_write) begin
        pc_d = pc_plus4_s;
      end else begin
        pc_d = pc_q;
      end
      if (bus.if_id_write) begin
        instr_d = bus.imem_rdata;
        pc4_d   = pc_plus4_s;
        valid_d = 1'b1;
      end else begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
      end
    end
  end

  // PC and IF/ID registers with synchronous reset to a bubble at RESET_PC.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP_WORD;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign bus.pc                = pc_q;
  assign bus.if_id_instruction = instr_q;
  assign bus.if_id_pc_plus4    = pc4_q;
  assign bus.if_id_valid       = valid_q;

`ifdef IF_STALL_COUNTER_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  // Count hazard-held PC edges, saturating instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!bus.pc_write && !bus.branch_taken && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall counter register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'h0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall_count = stall_cnt_q;
`endif

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, meaning PC value loaded on reset.
REQ-002 Parameter NOP_WORD, default 32'h0000_0000, meaning instruction word injected into IF/ID on flush or reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 pc_write  input  1  from hazard detection; 1 = PC may advance, 0 = PC holds.
REQ-006 if_id_write  input  1  from hazard detection; 1 = IF/ID may load, 0 = IF/ID holds.
REQ-007 branch_taken  input  1  resolved branch/jump from EX/MEM; redirect PC and flush IF/ID.
REQ-008 branch_target  input  32  redirect address, used when branch_taken=1.
REQ-009 imem_rdata  input  32  instruction word at address pc, combinational from instruction memory.
REQ-010 pc  output  32  current fetch address, registered.
REQ-011 if_id_instruction  output  32  IF/ID instruction, registered; feeds hazard detection and decode.
REQ-012 if_id_pc_plus4  output  32  IF/ID copy of fetch PC + 4, registered.
REQ-013 if_id_valid  output  1  1 = IF/ID holds a real fetched instruction, 0 = bubble.

Function
REQ-014 Next PC computed as pc + 32'd4, modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-015 Per-edge priority: reset > branch_taken > stall (pc_write/if_id_write = 0) > normal advance.
REQ-016 Normal (pc_write=1, if_id_write=1, branch_taken=0): pc <= pc+4; if_id_instruction <= imem_rdata; if_id_pc_plus4 <= pc+4; if_id_valid <= 1.
REQ-017 pc_write=0, branch_taken=0: pc holds its value.
REQ-018 if_id_write=0, branch_taken=0: if_id_instruction, if_id_pc_plus4, if_id_valid all hold.
REQ-019 pc_write and if_id_write are honoured independently; pc_write=1 with if_id_write=0 advances PC while IF/ID holds (the fetched word is dropped).
REQ-020 branch_taken=1: pc <= branch_target; if_id_instruction <= NOP_WORD; if_id_pc_plus4 <= 0; if_id_valid <= 0; regardless of pc_write/if_id_write.
REQ-021 Branch during stall: branch wins; stall is not remembered, and the next cycle evaluates fresh inputs.
REQ-022 Latency: imem_rdata sampled at edge N appears on if_id_instruction after edge N; a redirect takes effect on pc one edge after branch_taken is sampled.
REQ-023 branch_target is used as-is; bits [1:0] are not masked.
REQ-024 No output depends combinationally on any input; all outputs come directly from registers.

Reset
REQ-025 On a clk edge with reset=1: pc <= RESET_PC; if_id_instruction <= NOP_WORD; if_id_pc_plus4 <= 0; if_id_valid <= 0.
REQ-026 reset overrides branch_taken, pc_write, and if_id_write in the same cycle.
REQ-027 Reset asserted mid-stall or mid-redirect discards all pending state; the first non-reset edge fetches from RESET_PC.

Configuration
REQ-028 Macro IF_STALL_COUNTER_EN: when defined, adds output stall_count (16 bits) that increments on every non-reset edge where pc_write=0 and branch_taken=0, saturates at 16'hFFFF, and clears to 0 on reset.
REQ-029 Without IF_STALL_COUNTER_EN, the stall_count port and its register are absent, and all other behaviour is identical.

Verification
REQ-030 Reset, then 3 edges with pc_write=if_id_write=1 and imem_rdata=32'h2008_0005 -> pc=0x0C, if_id_instruction=0x2008_0005, if_id_pc_plus4=0x0C, if_id_valid=1.
REQ-031 At pc=0x10 drive pc_write=if_id_write=0 for 2 edges -> pc stays 0x10 and IF/ID is unchanged; release -> pc=0x14 after the next edge.
REQ-032 At pc=0x20 with stall active, assert branch_taken=1, branch_target=0x100 -> after the edge pc=0x100, if_id_instruction=NOP_WORD, if_id_valid=0.
REQ-033 Force pc=0xFFFF_FFFC via branch_target, then advance -> pc=0x0000_0000 and if_id_pc_plus4=0x0000_0000.
REQ-034 Assert reset while branch_taken=1 and pc_write=0 -> pc=RESET_PC and if_id_valid=0; with IF_STALL_COUNTER_EN, stall_count=0.
REQ-035 With IF_STALL_COUNTER_EN, preload stall_count to 16'hFFFE and stall for 3 edges -> stall_count=16'hFFFF, with no wrap.
